// File: rtl/ik_swift_iter_ctrl.sv
// Closed-loop iteration controller for the ik_swift solver core: starts the core, applies scaled
// and clamped deltas to N joint params, and stops on convergence or on the iteration limit.
module ik_swift_iter_ctrl #(
  parameter int NUM_JOINTS  = 6,
  parameter int DH_W        = 21,
  parameter int DELTA_W     = 36,
  parameter int DELTA_SHIFT = 15,
  parameter int ITER_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [ITER_W-1:0]                    iter_limit,
  input  logic [DELTA_W-1:0]                   tol,
  input  logic [NUM_JOINTS-1:0][DH_W-1:0]      dh_init,
  input  logic [NUM_JOINTS-1:0][DH_W-1:0]      dh_min,
  input  logic [NUM_JOINTS-1:0][DH_W-1:0]      dh_max,
  output logic                                 core_en,
  output logic [NUM_JOINTS-1:0][DH_W-1:0]      core_dh,
  input  logic                                 core_done,
  input  logic [NUM_JOINTS-1:0][DELTA_W-1:0]   core_delta,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic [ITER_W-1:0]                    iter_count,
  output logic [NUM_JOINTS-1:0][DH_W-1:0]      dh_out,
  output logic [2:0]                           dbg_state
);

  // Core handshake: core_en is a one-cycle start pulse; core_delta is taken on the first cycle
  // core_done is high while in WAIT, and core_done in any other state has no effect.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
  localparam int SW = DH_W + 1;
  localparam int AW = DH_W + 2;
  localparam int XW = (DELTA_W > AW) ? DELTA_W : AW;
  localparam logic [JW-1:0] LAST_J = JW'(NUM_JOINTS - 1);
  localparam logic signed [XW-1:0] STEP_MAX = $signed((XW'(1) << (SW - 1)) - XW'(1));
  localparam logic signed [XW-1:0] STEP_MIN = ~STEP_MAX;
  localparam logic [DELTA_W-1:0] DELTA_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

  state_t                               r_state;
  logic [NUM_JOINTS-1:0][DH_W-1:0]      r_dh;
  logic [NUM_JOINTS-1:0][DELTA_W-1:0]   r_delta;
  logic [NUM_JOINTS-1:0][DH_W-1:0]      r_dh_out;
  logic [JW-1:0]                        r_jidx;
  logic [ITER_W-1:0]                    r_iter;
  logic [ITER_W-1:0]                    r_limit;
  logic [ITER_W-1:0]                    r_iter_count;
  logic [DELTA_W-1:0]                   r_tol;
  logic                                 r_all_small;
  logic                                 r_core_en;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_converged;

  logic signed [DELTA_W-1:0] w_delta_j;
  logic signed [DELTA_W-1:0] w_shifted;
  logic signed [XW-1:0]      w_shifted_x;
  logic signed [XW-1:0]      w_step_x;
  logic signed [AW-1:0]      w_step;
  logic signed [AW-1:0]      w_sum;
  logic signed [AW-1:0]      w_min;
  logic signed [AW-1:0]      w_max;
  logic signed [AW-1:0]      w_clamped;
  logic [DELTA_W-1:0]        w_abs;
  logic                      w_small;
  logic [ITER_W:0]           w_iter_next;
  logic [ITER_W:0]           w_limit_eff;
  logic                      w_at_limit;

  // Per-joint update datapath; the sum is two bits wider than DH so clamping sees true overflow.
  always_comb begin
    w_delta_j   = r_delta[r_jidx];
    w_shifted   = w_delta_j >>> DELTA_SHIFT;
    w_shifted_x = XW'(w_shifted);
    if (w_shifted_x > STEP_MAX)      w_step_x = STEP_MAX;
    else if (w_shifted_x < STEP_MIN) w_step_x = STEP_MIN;
    else                             w_step_x = w_shifted_x;
    w_step = AW'(w_step_x);
    w_sum  = w_step + AW'($signed(r_dh[r_jidx]));
    w_min  = AW'($signed(dh_min[r_jidx]));
    w_max  = AW'($signed(dh_max[r_jidx]));
    if (w_sum < w_min)      w_clamped = w_min;
    else if (w_sum > w_max) w_clamped = w_max;
    else                    w_clamped = w_sum;
    w_abs   = w_delta_j[DELTA_W-1] ? ($unsigned(~w_delta_j) + DELTA_W'(1)) : $unsigned(w_delta_j);
    w_small = (w_abs <= r_tol) && ($unsigned(w_delta_j) != DELTA_MIN);
    w_iter_next = {1'b0, r_iter} + (ITER_W+1)'(1);
    w_limit_eff = (r_limit == '0) ? (ITER_W+1)'(1) : {1'b0, r_limit};
    w_at_limit  = (w_iter_next >= w_limit_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_dh         <= '0;
      r_delta      <= '0;
      r_dh_out     <= '0;
      r_jidx       <= '0;
      r_iter       <= '0;
      r_limit      <= '0;
      r_iter_count <= '0;
      r_tol        <= '0;
      r_all_small  <= 1'b0;
      r_core_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
    end else begin
      r_core_en <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_dh        <= dh_init;
          r_iter      <= '0;
          r_converged <= 1'b0;
          r_limit     <= iter_limit;
          r_tol       <= tol;
          r_all_small <= 1'b1;
          r_core_en   <= 1'b1;
          r_state     <= S_RUN;
        end
        S_RUN: r_state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            r_delta <= core_delta;
            r_jidx  <= '0;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_dh[r_jidx] <= w_clamped[DH_W-1:0];
          r_all_small  <= r_all_small & w_small;
          if (r_jidx == LAST_J) r_state <= S_CHECK;
          else                  r_jidx  <= r_jidx + JW'(1);
        end
        S_CHECK: begin
          r_iter_count <= w_iter_next[ITER_W-1:0];
          if (r_all_small || w_at_limit) begin
            r_converged <= r_all_small;
            r_dh_out    <= r_dh;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_iter      <= w_iter_next[ITER_W-1:0];
            r_all_small <= 1'b1;
            r_core_en   <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_en    = r_core_en;
  assign core_dh    = r_dh;
  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_converged;
  assign iter_count = r_iter_count;
  assign dh_out     = r_dh_out;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
// Directed bench for ik_swift_iter_ctrl: the bench plays the solver core and checks final params,
// iteration counts, convergence flag, core_en pulse counts and done pulse width.
module tb_ik_swift_iter_ctrl;

  localparam int N    = 6;
  localparam int DH_W = 21;
  localparam int DW   = 36;
  localparam int IW   = 8;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic [IW-1:0]            iter_limit;
  logic [DW-1:0]            tol;
  logic [N-1:0][DH_W-1:0]   dh_init;
  logic [N-1:0][DH_W-1:0]   dh_min;
  logic [N-1:0][DH_W-1:0]   dh_max;
  logic                     core_en;
  logic [N-1:0][DH_W-1:0]   core_dh;
  logic                     core_done;
  logic [N-1:0][DW-1:0]     core_delta;
  logic                     busy;
  logic                     done;
  logic                     converged;
  logic [IW-1:0]            iter_count;
  logic [N-1:0][DH_W-1:0]   dh_out;
  logic [2:0]               dbg_state;

  int checks   = 0;
  int failures = 0;

  ik_swift_iter_ctrl #(
    .NUM_JOINTS(N), .DH_W(DH_W), .DELTA_W(DW), .DELTA_SHIFT(15), .ITER_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .iter_limit(iter_limit), .tol(tol),
    .dh_init(dh_init), .dh_min(dh_min), .dh_max(dh_max),
    .core_en(core_en), .core_dh(core_dh), .core_done(core_done), .core_delta(core_delta),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .dh_out(dh_out), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DH_W-1:0] dhv(input int v);
    return v[DH_W-1:0];
  endfunction

  function automatic logic [DW-1:0] dv(input longint v);
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic default_setup();
    for (int j = 0; j < N; j++) begin
      dh_init[j]    = '0;
      dh_min[j]     = dhv(-1048576);
      dh_max[j]     = dhv(1048575);
      core_delta[j] = '0;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Acts as the solver core until the done pulse has come and gone.
  task automatic serve(input int lat, input int hold, input int en_at,
                       output int n_en, output int done_w);
    int pend;
    int hold_left;
    int cyc;
    bit seen;
    n_en = 0; done_w = 0; pend = 0; hold_left = 0; cyc = 0; seen = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      en = (cyc == en_at);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          hold_left = hold;
        end
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) core_done = 1'b0;
      end
      if (core_en) begin
        n_en++;
        pend = lat;
      end
      if (done) begin
        done_w++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    core_done = 1'b0;
    en = 1'b0;
    check("serve_done_seen", 64'(seen), 64'd1);
  endtask

  int n_en;
  int done_w;
  int waited;
  int idle_en;
  int idle_busy;

  initial begin
    rst = 1'b0; en = 1'b0; core_done = 1'b0; iter_limit = '0; tol = '0;
    default_setup();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_core_en", 64'(core_en), 64'd0);
    check("rst_iter_count", 64'(iter_count), 64'd0);
    check("rst_converged", 64'(converged), 64'd0);
    check("rst_dh_out0", 64'(dh_out[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Zero deltas converge in one iteration and leave params untouched.
    default_setup();
    dh_init[0] = dhv(10);  dh_init[1] = dhv(-20); dh_init[2] = dhv(30);
    dh_init[3] = dhv(-40); dh_init[4] = dhv(50);  dh_init[5] = dhv(-60);
    iter_limit = 8'd5; tol = dv(16);
    start_run();
    serve(1, 1, 0, n_en, done_w);
    check("zero_n_core_en", 64'(n_en), 64'd1);
    check("zero_done_width", 64'(done_w), 64'd1);
    check("zero_converged", 64'(converged), 64'd1);
    check("zero_iter_count", 64'(iter_count), 64'd1);
    check("zero_dh_out0", 64'(dh_out[0]), 64'(dhv(10)));
    check("zero_dh_out3", 64'(dh_out[3]), 64'(dhv(-40)));
    check("zero_dh_out5", 64'(dh_out[5]), 64'(dhv(-60)));

    // Reset while waiting on the core.
    start_run();
    waited = 0;
    while (!core_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("midwait_core_en_seen", 64'(core_en), 64'd1);
    repeat (2) @(negedge clk);
    check("midwait_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midwait_rst_busy", 64'(busy), 64'd0);
    check("midwait_rst_done", 64'(done), 64'd0);
    check("midwait_rst_core_en", 64'(core_en), 64'd0);
    check("midwait_rst_dh_out0", 64'(dh_out[0]), 64'd0);
    check("midwait_rst_dh_out5", 64'(dh_out[5]), 64'd0);
    check("midwait_rst_iter", 64'(iter_count), 64'd0);
    rst = 1'b1;

    // Constant step of +32 for three iterations.
    default_setup();
    dh_init[0] = dhv(100); dh_init[1] = dhv(-7);
    core_delta[0] = dv(64'sd1 << 20);
    iter_limit = 8'd3; tol = dv(16);
    start_run();
    serve(2, 1, 0, n_en, done_w);
    check("step_n_core_en", 64'(n_en), 64'd3);
    check("step_dh_out0", 64'(dh_out[0]), 64'(dhv(196)));
    check("step_dh_out1", 64'(dh_out[1]), 64'(dhv(-7)));
    check("step_converged", 64'(converged), 64'd0);
    check("step_iter_count", 64'(iter_count), 64'd3);

    // Clamping high and low, floor of a small negative step, and wide-sum overflow.
    default_setup();
    dh_init[1] = dhv(50);
    dh_init[2] = dhv(1000);  dh_max[2] = dhv(1010);
    dh_init[3] = dhv(-1000); dh_min[3] = dhv(-1005);
    dh_init[4] = dhv(5);
    core_delta[1] = dv(-5);
    core_delta[2] = dv(64 << 15);
    core_delta[3] = dv(-(64 << 15));
    core_delta[4] = dv((64'sd1 << 35) - 1);
    iter_limit = 8'd1; tol = dv(16);
    start_run();
    serve(3, 1, 0, n_en, done_w);
    check("clamp_dh_out1", 64'(dh_out[1]), 64'(dhv(49)));
    check("clamp_dh_out2", 64'(dh_out[2]), 64'(dhv(1010)));
    check("clamp_dh_out3", 64'(dh_out[3]), 64'(dhv(-1005)));
    check("clamp_dh_out4", 64'(dh_out[4]), 64'(dhv(1048575)));
    check("clamp_dh_out0", 64'(dh_out[0]), 64'd0);
    check("clamp_iter_count", 64'(iter_count), 64'd1);

    // Limit 0 acts as 1; the most negative delta is never small even with maximal tol.
    default_setup();
    dh_init[0] = dhv(100);
    core_delta[0] = dv(-(64'sd1 << 35));
    iter_limit = 8'd0; tol = '1;
    start_run();
    serve(1, 1, 0, n_en, done_w);
    check("lim0_n_core_en", 64'(n_en), 64'd1);
    check("lim0_iter_count", 64'(iter_count), 64'd1);
    check("lim0_converged", 64'(converged), 64'd0);
    check("lim0_dh_out0", 64'(dh_out[0]), 64'(dhv(-1048476)));

    // en re-pulsed while busy, core_done held high into UPDATE.
    default_setup();
    dh_init[5] = dhv(7);
    core_delta[5] = dv(3 << 15);
    iter_limit = 8'd2; tol = '0;
    start_run();
    serve(1, 4, 3, n_en, done_w);
    check("busy_n_core_en", 64'(n_en), 64'd2);
    check("busy_done_width", 64'(done_w), 64'd1);
    check("busy_iter_count", 64'(iter_count), 64'd2);
    check("busy_converged", 64'(converged), 64'd0);
    check("busy_dh_out5", 64'(dh_out[5]), 64'(dhv(13)));
    idle_en = 0; idle_busy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (core_en) idle_en++;
      if (busy) idle_busy++;
    end
    check("busy_no_restart_core_en", 64'(idle_en), 64'd0);
    check("busy_no_restart_busy", 64'(idle_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
